// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants and
// the default baud prescaler setting.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  // 12 MHz / (115200 * 16) rounds to 6.5; the prescaler counts 0..6.
  localparam logic [7:0] DEFAULT_DIVIDER = 8'd6;

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick prescaler: one tick every freq_divider+1 clocks, with a
// synchronous clear so the receiver can phase-align ticks to a start edge.
`timescale 1ns/1ps
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] freq_divider,
  output logic       tick
);

  logic [7:0] count;
  logic [7:0] divider;

  // Divider is re-latched only at a wrap or a clear so a live change never truncates a period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 8'd0;
      divider <= DEFAULT_DIVIDER;
    end else if (clear) begin
      count   <= 8'd0;
      divider <= freq_divider;
    end else if (count == divider) begin
      count   <= 8'd0;
      divider <= freq_divider;
    end else begin
      count   <= count + 8'd1;
      divider <= divider;
    end
  end

  assign tick = (count == divider) && !clear;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling; emits a
// one-clock rx_valid strobe per good byte and a frame_err strobe per bad stop bit.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_bit,
  input  logic [7:0]           freq_divider,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] MID_CNT  = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic                 tick;
  logic                 clear;
  logic [SW-1:0]        samp;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;

  // Two-flop synchroniser, reset to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx_bit};
    end
  end

  assign rx_s  = sync[1];
  assign clear = (state == ST_IDLE) && !rx_s;

  uart_baud_tick u_baud_tick (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .freq_divider (freq_divider),
    .tick         (tick)
  );

  // Frame FSM; strobes default low each clock so they last exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      samp      <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            samp  <= '0;
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (samp == MID_CNT) begin
              samp <= '0;
              if (!rx_s) begin
                idx   <= '0;
                state <= ST_DATA;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              samp <= samp + SW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (samp == LAST_CNT) begin
              samp  <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (idx == LAST_IDX) begin
                state <= ST_STOP;
              end else begin
                idx <= idx + IW'(1);
              end
            end else begin
              samp <= samp + SW'(1);
            end
          end
        end
        ST_STOP: begin
          // Leaving mid-stop-bit lets a back-to-back start edge be caught at once.
          if (tick) begin
            if (samp == LAST_CNT) begin
              samp <= '0;
              if (rx_s) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                state    <= ST_IDLE;
                busy     <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_BREAK;
              end
            end else begin
              samp <= samp + SW'(1);
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
